// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_hazard_ctrl_if : pipeline-stage view and hazard-control bus |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   logic [31:0]      ID_instr;
   logic [31:0]      EX_instr;
   logic [4:0]       EX_WriteDst;
   logic [31:0]      MEM_instr;
   logic             branch_taken;
   logic             dmem_ack;
   logic             pc_en;
   logic             if_id_en;
   logic             id_ex_en;
   logic             ex_mem_en;
   logic             mem_wb_en;
   logic             if_id_flush;
   logic             id_ex_flush;
   logic             dmem_req;
   logic [1:0]       state;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cnt;

   modport slave (
      input  ID_instr, EX_instr, EX_WriteDst, MEM_instr, branch_taken, dmem_ack,
      output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
      output if_id_flush, id_ex_flush, dmem_req, state, mem_err, stall_cnt
   );

   modport master (
      output ID_instr, EX_instr, EX_WriteDst, MEM_instr, branch_taken, dmem_ack,
      input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
      input  if_id_flush, id_ex_flush, dmem_req, state, mem_err, stall_cnt
   );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | pipe_hazard_ctrl : load-use / branch / memory-freeze controller  |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 16
) (
   input  wire logic         clk,
   input  wire logic         rst,
   pipe_hazard_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MEM_WAIT = 2'd1,
      ST_RELEASE  = 2'd2
   } state_t;

   localparam logic [5:0] c_OP_LW    = 6'b100011;
   localparam logic [5:0] c_OP_SW    = 6'b101011;
   localparam logic [7:0] c_TMR_LAST = 8'(MEM_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [7:0]       timer_q, timer_d;
   logic             mem_err_q, mem_err_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   logic w_mem_op, w_load_use;
   logic w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en;
   logic w_if_id_flush, w_id_ex_flush, w_dmem_req;

   assign w_mem_op   = (bus.MEM_instr[31:26] == c_OP_LW) || (bus.MEM_instr[31:26] == c_OP_SW);
   assign w_load_use = (bus.EX_instr[31:26] == c_OP_LW) && (bus.EX_WriteDst != 5'd0) &&
                       ((bus.EX_WriteDst == bus.ID_instr[25:21]) ||
                        (bus.EX_WriteDst == bus.ID_instr[20:16]));

   always_comb begin
      state_d       = state_q;
      timer_d       = timer_q;
      mem_err_d     = mem_err_q;
      w_pc_en       = 1'b0;
      w_if_id_en    = 1'b0;
      w_id_ex_en    = 1'b0;
      w_ex_mem_en   = 1'b0;
      w_mem_wb_en   = 1'b0;
      w_if_id_flush = 1'b0;
      w_id_ex_flush = 1'b0;
      w_dmem_req    = 1'b0;
      case (state_q)
         ST_RUN: begin
            w_dmem_req = w_mem_op;
            // Freeze outranks branch, branch outranks load-use.
            if (w_mem_op && !bus.dmem_ack) begin
               state_d = ST_MEM_WAIT;
               timer_d = 8'd0;
            end else if (bus.branch_taken) begin
               {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b11111;
               w_if_id_flush = 1'b1;
               w_id_ex_flush = 1'b1;
            end else if (w_load_use) begin
               {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b00111;
               w_id_ex_flush = 1'b1;
            end else begin
               {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b11111;
            end
         end
         ST_MEM_WAIT: begin
            w_dmem_req = w_mem_op;
            timer_d    = timer_q + 8'd1;
            if (bus.dmem_ack) begin
               {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b11111;
               state_d = ST_RUN;
            end else if (timer_q == c_TMR_LAST) begin
               mem_err_d = 1'b1;
               state_d   = ST_RELEASE;
            end
         end
         ST_RELEASE: begin
            {w_pc_en, w_if_id_en, w_id_ex_en, w_ex_mem_en, w_mem_wb_en} = 5'b11111;
            state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
      stall_cnt_d = stall_cnt_q;
      if (!w_pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_RUN;
         timer_q     <= 8'd0;
         mem_err_q   <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         mem_err_q   <= mem_err_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign bus.pc_en       = w_pc_en       & ~rst;
   assign bus.if_id_en    = w_if_id_en    & ~rst;
   assign bus.id_ex_en    = w_id_ex_en    & ~rst;
   assign bus.ex_mem_en   = w_ex_mem_en   & ~rst;
   assign bus.mem_wb_en   = w_mem_wb_en   & ~rst;
   assign bus.if_id_flush = w_if_id_flush & ~rst;
   assign bus.id_ex_flush = w_id_ex_flush & ~rst;
   assign bus.dmem_req    = w_dmem_req    & ~rst;
   assign bus.state       = state_q;
   assign bus.mem_err     = mem_err_q;
   assign bus.stall_cnt   = stall_cnt_q;

   logic unused_bits;
   assign unused_bits = ^{bus.ID_instr[31:26], bus.ID_instr[15:0],
                          bus.EX_instr[25:0], bus.MEM_instr[25:0]};
endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_pipe_hazard_ctrl : directed bench for pipe_hazard_ctrl        |
// | Revision 1.0                                                     |
// +------------------------------------------------------------------+
module tb_pipe_hazard_ctrl;
   logic clk;
   logic rst;
   int   errors;
   int   checks;
   int   exp_stall;

   pipe_hazard_ctrl_if #(.CNT_W(16)) bus ();
   pipe_hazard_ctrl_if #(.CNT_W(4))  bus4 ();

   pipe_hazard_ctrl #(.MEM_TIMEOUT(16), .CNT_W(16)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   pipe_hazard_ctrl #(.MEM_TIMEOUT(32), .CNT_W(4)) u_dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   localparam logic [31:0] c_LW  = {6'b100011, 26'd0};
   localparam logic [31:0] c_SW  = {6'b101011, 26'd0};
   localparam logic [31:0] c_NOP = 32'd0;

   logic [4:0] en;
   logic [1:0] fl;
   assign en = {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en};
   assign fl = {bus.if_id_flush, bus.id_ex_flush};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time exhausted, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_idle();
      bus.ID_instr     = c_NOP;
      bus.EX_instr     = c_NOP;
      bus.EX_WriteDst  = 5'd0;
      bus.MEM_instr    = c_NOP;
      bus.branch_taken = 1'b0;
      bus.dmem_ack     = 1'b0;
   endtask

   task automatic test_reset();
      rst              = 1'b1;
      bus.ID_instr     = {6'd0, 5'd5, 5'd0, 16'd0};
      bus.EX_instr     = c_LW;
      bus.EX_WriteDst  = 5'd5;
      bus.MEM_instr    = c_LW;
      bus.branch_taken = 1'b1;
      bus.dmem_ack     = 1'b0;
      bus4.ID_instr = c_NOP; bus4.EX_instr = c_NOP; bus4.EX_WriteDst = 5'd0;
      bus4.MEM_instr = c_NOP; bus4.branch_taken = 1'b0; bus4.dmem_ack = 1'b0;
      repeat (2) tick();
      checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", bus.state); end
      checks++; if (en !== 5'b00000) begin errors++; $display("FAIL reset_enables: got %b expected 00000", en); end
      checks++; if ({fl, bus.dmem_req} !== 3'b000) begin errors++; $display("FAIL reset_flush_req: got %b expected 000", {fl, bus.dmem_req}); end
      checks++; if ({bus.mem_err, bus.stall_cnt} !== 17'd0) begin errors++; $display("FAIL reset_err_cnt: got %0h expected 0", {bus.mem_err, bus.stall_cnt}); end
      set_idle();
      rst = 1'b0;
      exp_stall = 0;
      #1;
      checks++; if ({en, fl, bus.dmem_req} !== 8'b11111_00_0) begin errors++; $display("FAIL idle_outputs: got %b expected 11111000", {en, fl, bus.dmem_req}); end
      tick();
      checks++; if (bus.stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL idle_stall_cnt: got %0d expected %0d", bus.stall_cnt, exp_stall); end
   endtask

   task automatic test_load_use();
      // EX lw r5, ID rs=r5
      bus.EX_instr = c_LW; bus.EX_WriteDst = 5'd5; bus.ID_instr = {6'd0, 5'd5, 5'd0, 16'd0};
      #1;
      checks++; if ({en, fl} !== 7'b00111_01) begin errors++; $display("FAIL load_use_rs: got %b expected 0011101", {en, fl}); end
      tick(); exp_stall++;
      set_idle(); #1;
      checks++; if (bus.stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL load_use_cnt: got %0d expected %0d", bus.stall_cnt, exp_stall); end
      checks++; if (en !== 5'b11111) begin errors++; $display("FAIL load_use_single: got %b expected 11111", en); end
      // rt match
      bus.EX_instr = c_LW; bus.EX_WriteDst = 5'd7; bus.ID_instr = {6'd0, 5'd3, 5'd7, 16'd0};
      #1;
      checks++; if ({en, fl} !== 7'b00111_01) begin errors++; $display("FAIL load_use_rt: got %b expected 0011101", {en, fl}); end
      tick(); exp_stall++;
      // r0 destination never stalls
      bus.EX_WriteDst = 5'd0; bus.ID_instr = {6'd0, 5'd0, 5'd0, 16'd0};
      #1;
      checks++; if ({en, fl} !== 7'b11111_00) begin errors++; $display("FAIL load_use_r0: got %b expected 1111100", {en, fl}); end
      // store in EX is not a load
      bus.EX_instr = c_SW; bus.EX_WriteDst = 5'd5; bus.ID_instr = {6'd0, 5'd5, 5'd0, 16'd0};
      #1;
      checks++; if (en !== 5'b11111) begin errors++; $display("FAIL sw_no_stall: got %b expected 11111", en); end
      tick(); set_idle(); #1;
      checks++; if (bus.stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL load_use_cnt2: got %0d expected %0d", bus.stall_cnt, exp_stall); end
   endtask

   task automatic test_branch();
      bus.EX_instr = c_LW; bus.EX_WriteDst = 5'd5; bus.ID_instr = {6'd0, 5'd5, 5'd0, 16'd0};
      bus.branch_taken = 1'b1;
      #1;
      checks++; if ({en, fl} !== 7'b11111_11) begin errors++; $display("FAIL branch_over_load_use: got %b expected 1111111", {en, fl}); end
      tick(); set_idle(); #1;
      checks++; if (bus.stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL branch_cnt: got %0d expected %0d", bus.stall_cnt, exp_stall); end
   endtask

   task automatic test_mem_wait();
      // ack in the same cycle: no stall
      bus.MEM_instr = c_LW; bus.dmem_ack = 1'b1;
      #1;
      checks++; if ({en, bus.dmem_req} !== 6'b11111_1) begin errors++; $display("FAIL mem_fast_ack: got %b expected 111111", {en, bus.dmem_req}); end
      tick();
      checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL mem_fast_state: got %0d expected 0", bus.state); end
      // ack low in RUN then 3 MEM_WAIT cycles, then ack
      bus.dmem_ack = 1'b0; bus.branch_taken = 1'b1;
      #1;
      checks++; if ({en, fl, bus.dmem_req} !== 8'b00000_00_1) begin errors++; $display("FAIL mem_enter: got %b expected 00000001", {en, fl, bus.dmem_req}); end
      tick(); exp_stall++;
      for (int i = 0; i < 3; i++) begin
         checks++; if ({bus.state, en, fl, bus.dmem_req} !== 10'b01_00000_00_1) begin errors++; $display("FAIL mem_wait_%0d: got %b expected 0100000001", i, {bus.state, en, fl, bus.dmem_req}); end
         tick(); exp_stall++;
      end
      bus.dmem_ack = 1'b1;
      #1;
      checks++; if ({bus.state, en, fl} !== 9'b01_11111_00) begin errors++; $display("FAIL mem_ack: got %b expected 011111100", {bus.state, en, fl}); end
      tick(); set_idle();
      checks++; if (bus.state !== 2'd0) begin errors++; $display("FAIL mem_back_run: got %0d expected 0", bus.state); end
      checks++; if (bus.stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL mem_cnt: got %0d expected %0d", bus.stall_cnt, exp_stall); end
   endtask

   task automatic test_timeout();
      bus.MEM_instr = c_SW; bus.dmem_ack = 1'b0;
      tick(); exp_stall++;
      for (int i = 0; i < 16; i++) begin
         checks++; if ({bus.state, bus.mem_err} !== 3'b01_0) begin errors++; $display("FAIL timeout_wait_%0d: got %b expected 010", i, {bus.state, bus.mem_err}); end
         tick(); exp_stall++;
      end
      checks++; if ({bus.state, bus.mem_err, bus.dmem_req, en} !== 9'b10_1_0_11111) begin errors++; $display("FAIL timeout_release: got %b expected 101011111", {bus.state, bus.mem_err, bus.dmem_req, en}); end
      set_idle();
      tick();
      checks++; if ({bus.state, bus.mem_err} !== 3'b00_1) begin errors++; $display("FAIL timeout_sticky: got %b expected 001", {bus.state, bus.mem_err}); end
      checks++; if (bus.stall_cnt !== 16'(exp_stall)) begin errors++; $display("FAIL timeout_cnt: got %0d expected %0d", bus.stall_cnt, exp_stall); end
   endtask

   task automatic test_reset_mid_wait();
      bus.MEM_instr = c_LW; bus.dmem_ack = 1'b0;
      repeat (2) tick();
      checks++; if (bus.state !== 2'd1) begin errors++; $display("FAIL pre_reset_wait: got %0d expected 1", bus.state); end
      rst = 1'b1;
      #1;
      checks++; if ({bus.state, bus.dmem_req, bus.mem_err} !== 4'b00_0_0) begin errors++; $display("FAIL async_reset: got %b expected 0000", {bus.state, bus.dmem_req, bus.mem_err}); end
      checks++; if (bus.stall_cnt !== 16'd0) begin errors++; $display("FAIL async_reset_cnt: got %0d expected 0", bus.stall_cnt); end
      set_idle();
      tick();
      rst = 1'b0; exp_stall = 0;
      tick();
      checks++; if ({bus.state, bus.mem_err, bus.stall_cnt} !== 19'd0) begin errors++; $display("FAIL post_reset: got %0h expected 0", {bus.state, bus.mem_err, bus.stall_cnt}); end
   endtask

   task automatic test_saturate();
      bus4.MEM_instr = c_LW; bus4.dmem_ack = 1'b0;
      repeat (14) tick();
      checks++; if (bus4.stall_cnt !== 4'd14) begin errors++; $display("FAIL sat_14: got %0d expected 14", bus4.stall_cnt); end
      repeat (6) tick();
      checks++; if ({bus4.state, bus4.stall_cnt} !== 6'b01_1111) begin errors++; $display("FAIL sat_20: got %b expected 011111", {bus4.state, bus4.stall_cnt}); end
      bus4.dmem_ack = 1'b1;
      tick();
      bus4.MEM_instr = c_NOP; bus4.dmem_ack = 1'b0;
      tick();
      checks++; if ({bus4.state, bus4.stall_cnt} !== 6'b00_1111) begin errors++; $display("FAIL sat_hold: got %b expected 001111", {bus4.state, bus4.stall_cnt}); end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      exp_stall = 0;
      test_reset();
      test_load_use();
      test_branch();
      test_mem_wait();
      test_timeout();
      test_reset_mid_wait();
      test_saturate();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 16: maximum MEM_WAIT cycles before forced release; legal range 2..255.
REQ-002 Parameter CNT_W, default 16: width of the stall_cnt performance counter.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ID_instr  in  32  instruction held in IF/ID; rs=[25:21], rt=[20:16].
REQ-006 EX_instr  in  32  instruction held in ID/EX; opcode=[31:26].
REQ-007 EX_WriteDst  in  5  destination register of the EX-stage instruction.
REQ-008 MEM_instr  in  32  instruction held in EX/MEM; opcode=[31:26].
REQ-009 branch_taken  in  1  EX-stage redirect, valid only while the pipeline is not frozen.
REQ-010 dmem_ack  in  1  data-memory completion for the current MEM-stage access.
REQ-011 pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en  out  1 each  load enables for PC and the four pipeline registers.
REQ-012 if_id_flush, id_ex_flush  out  1 each  load a NOP (all-zero) into IF/ID or ID/EX on the next edge.
REQ-013 dmem_req  out  1  data-memory access request.
REQ-014 state  out  2  FSM state: 0=RUN, 1=MEM_WAIT, 2=RELEASE.
REQ-015 mem_err  out  1  sticky memory-timeout flag.
REQ-016 stall_cnt  out  CNT_W  count of cycles with pc_en=0, saturating.

Function
REQ-017 A load is opcode 6'b100011; a store is opcode 6'b101011; a memory op is either.
REQ-018 dmem_req SHALL equal 1 whenever MEM_instr is a memory op and state is RUN or MEM_WAIT; otherwise 0.
REQ-019 RUN, memory op, dmem_ack=0: all five enables 0, no flush, next state MEM_WAIT, timer cleared to 0.
REQ-020 RUN, memory op, dmem_ack=1 in the same cycle: no stall, state stays RUN.
REQ-021 MEM_WAIT: all five enables 0, flushes 0, timer increments by 1 per cycle.
REQ-022 MEM_WAIT with dmem_ack=1: all enables 1 in that cycle, next state RUN.
REQ-023 MEM_WAIT with timer=MEM_TIMEOUT-1 and dmem_ack=0: set mem_err, next state RELEASE.
REQ-024 RELEASE lasts exactly one cycle: all enables 1, dmem_req 0, then RUN; the access is treated as complete.
REQ-025 Load-use hazard in RUN, unfrozen: EX_instr is a load, EX_WriteDst!=0, and EX_WriteDst equals ID rs or ID rt.
REQ-026 Load-use response: pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1, mem_wb_en=1, for exactly that cycle.
REQ-027 branch_taken in RUN, unfrozen: all enables 1, if_id_flush=1, id_ex_flush=1.
REQ-028 Priority: memory freeze > branch_taken > load-use; a branch suppresses a simultaneous load-use stall.
REQ-029 branch_taken SHALL be ignored while frozen (MEM_WAIT, or RUN entering MEM_WAIT).
REQ-030 No hazard in RUN: all enables 1, flushes 0.
REQ-031 stall_cnt increments by 1 on each edge where pc_en=0; it holds at 2^CNT_W-1.
REQ-032 Enables and flushes are combinational from state and inputs; state, timer, mem_err and stall_cnt are registered.

Reset
REQ-033 While rst=1: state=RUN, timer=0, mem_err=0, stall_cnt=0.
REQ-034 While rst=1: all enables 0, flushes 0, dmem_req 0, regardless of other inputs.
REQ-035 Reset asserted in MEM_WAIT aborts the access immediately; mem_err is not set.
REQ-036 mem_err clears only on reset.

Verification
REQ-037 EX lw, WriteDst=5; ID rs=5 -> one cycle with pc_en=0, if_id_en=0, id_ex_flush=1; stall_cnt=1.
REQ-038 MEM lw, dmem_ack low for 3 cycles then high -> state=MEM_WAIT for 3 cycles, all enables 0; then enables 1 and state=RUN; stall_cnt=4.
REQ-039 MEM sw, dmem_ack never high, MEM_TIMEOUT=16 -> state=RELEASE after 16 MEM_WAIT cycles, mem_err=1, then RUN.
REQ-040 branch_taken=1 with a concurrent load-use hazard -> pc_en=1, if_id_flush=1, id_ex_flush=1, stall_cnt unchanged.
REQ-041 rst pulsed mid-MEM_WAIT -> state=0, dmem_req=0, mem_err=0, stall_cnt=0 asynchronously.
REQ-042 CNT_W=4, 20 consecutive frozen cycles -> stall_cnt=15.
